// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: FSM states,
// instruction classes, opcode/funct fields and the select/op codes driven
// to the datapath.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  // One class per distinct EXEC/MEM/WB behaviour.
  typedef enum logic [3:0] {
    CLS_RALU,
    CLS_SHIFT,
    CLS_ADDIU,
    CLS_LUI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_JR,
    CLS_JAL,
    CLS_ILLEGAL
  } inst_class_e;

  // Primary opcodes (instruction[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instruction[5:0]).
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // ALU operation codes.
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_SLT   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_LUI   = 4'd7;
  localparam logic [3:0] ALU_PASSA = 4'd8;

  // Operand-mux selects.
  localparam logic [1:0] SEL_A_RS   = 2'd0;
  localparam logic [1:0] SEL_A_PC   = 2'd1;
  localparam logic [1:0] SEL_A_RT   = 2'd2;
  localparam logic [1:0] SEL_B_IMM  = 2'd0;
  localparam logic [1:0] SEL_B_SA   = 2'd1;
  localparam logic [1:0] SEL_B_RT   = 2'd2;
  localparam logic [1:0] SEL_B_FOUR = 2'd3;

  // PC source and register-destination selects.
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;
  localparam logic [1:0] REG_DST_RT    = 2'd0;
  localparam logic [1:0] REG_DST_RD    = 2'd1;
  localparam logic [1:0] REG_DST_R31   = 2'd2;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the sequencer (master) and the datapath/memory
// side (slave): status inputs, the shared memory handshake and every
// select/strobe the sequencer drives.
interface mc_ctrl_fsm_if;
  logic [31:0] instruction;
  logic        alu_zero;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_src;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [1:0]  control_port_a;
  logic [1:0]  control_port_b;
  logic [3:0]  alu_op;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic        mem_to_reg;
  logic        inst_retired;
  logic        illegal_inst;

  modport master (
    input  instruction, alu_zero, mem_ack,
    output mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src,
           control_port_a, control_port_b, alu_op, reg_write, reg_dst,
           mem_to_reg, inst_retired, illegal_inst
  );

  modport slave (
    output instruction, alu_zero, mem_ack,
    input  mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src,
           control_port_a, control_port_b, alu_op, reg_write, reg_dst,
           mem_to_reg, inst_retired, illegal_inst
  );
endinterface

// File: rtl/mc_inst_decoder.sv
// Combinational instruction classifier: maps the IR contents to an
// instruction class, the ALU op used in EXEC and the write-back register
// select. Anything not recognised is flagged illegal.
module mc_inst_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] instruction,
  output inst_class_e inst_class,
  output logic [3:0]  alu_op,
  output logic [1:0]  reg_dst,
  output logic        illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_fields = ^instruction[25:6];

  // Classify by opcode, then by funct for R-type.
  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves it unassigned; a missing default here would infer a latch.
    inst_class = CLS_ILLEGAL;
    alu_op     = ALU_ADD;
    reg_dst    = REG_DST_RT;
    case (opcode)
      OP_RTYPE: begin
        reg_dst = REG_DST_RD;
        case (funct)
          FN_ADDU: begin inst_class = CLS_RALU;  alu_op = ALU_ADD; end
          FN_SUBU: begin inst_class = CLS_RALU;  alu_op = ALU_SUB; end
          FN_AND:  begin inst_class = CLS_RALU;  alu_op = ALU_AND; end
          FN_OR:   begin inst_class = CLS_RALU;  alu_op = ALU_OR;  end
          FN_SLT:  begin inst_class = CLS_RALU;  alu_op = ALU_SLT; end
          FN_SLL:  begin inst_class = CLS_SHIFT; alu_op = ALU_SLL; end
          FN_SRL:  begin inst_class = CLS_SHIFT; alu_op = ALU_SRL; end
          FN_JR:   inst_class = CLS_JR;
          default: inst_class = CLS_ILLEGAL;
        endcase
      end
      OP_ADDIU: inst_class = CLS_ADDIU;
      OP_LUI:   begin inst_class = CLS_LUI; alu_op = ALU_LUI; end
      OP_LW:    inst_class = CLS_LW;
      OP_SW:    inst_class = CLS_SW;
      OP_BEQ:   begin inst_class = CLS_BEQ; alu_op = ALU_SUB; end
      OP_BNE:   begin inst_class = CLS_BNE; alu_op = ALU_SUB; end
      OP_J:     inst_class = CLS_J;
      OP_JAL:   begin inst_class = CLS_JAL; alu_op = ALU_PASSA; reg_dst = REG_DST_R31; end
      default:  inst_class = CLS_ILLEGAL;
    endcase
    illegal = (inst_class == CLS_ILLEGAL);
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the MIPS
// core. Outputs are decoded from the current state and instruction class;
// the only input-dependent outputs are the fetch/memory completion strobes
// (on mem_ack) and the branch pc_write (on alu_zero). The single memory
// port is shared between fetch and load/store.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int RESET_VECTOR_WAIT = 1
) (
  input logic           clk,
  input logic           rst,
  mc_ctrl_fsm_if.master bus
);

  localparam logic [1:0] WAIT_LAST = 2'(RESET_VECTOR_WAIT - 1);

  state_e      state_q, state_d;
  logic [1:0]  rst_cnt_q, rst_cnt_d;

  inst_class_e dec_class;
  logic [3:0]  dec_alu_op;
  logic [1:0]  dec_reg_dst;
  logic        dec_illegal;

  mc_inst_decoder u_decoder (
    .instruction (bus.instruction),
    .inst_class  (dec_class),
    .alu_op      (dec_alu_op),
    .reg_dst     (dec_reg_dst),
    .illegal     (dec_illegal)
  );

  // State and reset-wait counter registers; reset forces S_RESET so every
  // strobe drops as soon as rst rises, even mid-access.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep all flops updating from the same
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_RESET;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d            = state_q;
    rst_cnt_d          = rst_cnt_q;
    bus.mem_req        = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_addr_src   = 1'b0;
    bus.ir_write       = 1'b0;
    bus.pc_write       = 1'b0;
    bus.pc_src         = PC_SRC_ALU;
    bus.control_port_a = SEL_A_RS;
    bus.control_port_b = SEL_B_IMM;
    bus.alu_op         = ALU_ADD;
    bus.reg_write      = 1'b0;
    bus.reg_dst        = REG_DST_RT;
    bus.mem_to_reg     = 1'b0;
    bus.inst_retired   = 1'b0;
    bus.illegal_inst   = 1'b0;

    case (state_q)
      S_RESET: begin
        if (rst_cnt_q == WAIT_LAST) state_d = S_FETCH;
        else                        rst_cnt_d = rst_cnt_q + 2'd1;
      end

      S_FETCH: begin
        bus.mem_req        = 1'b1;
        bus.control_port_a = SEL_A_PC;
        bus.control_port_b = SEL_B_FOUR;
        bus.alu_op         = ALU_ADD;
        if (bus.mem_ack) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          bus.pc_src   = PC_SRC_ALU;
          state_d      = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = dec_illegal ? S_TRAP : S_EXEC;
      end

      S_EXEC: begin
        bus.alu_op = dec_alu_op;
        case (dec_class)
          CLS_RALU: begin
            bus.control_port_a = SEL_A_RS;
            bus.control_port_b = SEL_B_RT;
            state_d            = S_WB;
          end
          CLS_SHIFT: begin
            bus.control_port_a = SEL_A_RT;
            bus.control_port_b = SEL_B_SA;
            state_d            = S_WB;
          end
          CLS_ADDIU, CLS_LUI: begin
            bus.control_port_b = SEL_B_IMM;
            state_d            = S_WB;
          end
          CLS_LW, CLS_SW: begin
            bus.control_port_b = SEL_B_IMM;
            state_d            = S_MEM;
          end
          CLS_BEQ, CLS_BNE: begin
            bus.control_port_a = SEL_A_RS;
            bus.control_port_b = SEL_B_RT;
            bus.pc_src         = PC_SRC_BRANCH;
            bus.pc_write       = bus.alu_zero ^ (dec_class == CLS_BNE);
            bus.inst_retired   = 1'b1;
            state_d            = S_FETCH;
          end
          CLS_J: begin
            bus.pc_write     = 1'b1;
            bus.pc_src       = PC_SRC_JUMP;
            bus.inst_retired = 1'b1;
            state_d          = S_FETCH;
          end
          CLS_JR: begin
            bus.pc_write     = 1'b1;
            bus.pc_src       = PC_SRC_RS;
            bus.inst_retired = 1'b1;
            state_d          = S_FETCH;
          end
          CLS_JAL: begin
            bus.control_port_a = SEL_A_PC;
            state_d            = S_WB;
          end
          default: state_d = S_TRAP;
        endcase
      end

      S_MEM: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_src = 1'b1;
        bus.mem_we       = (dec_class == CLS_SW);
        if (bus.mem_ack) begin
          if (dec_class == CLS_SW) begin
            bus.inst_retired = 1'b1;
            state_d          = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        bus.reg_write    = 1'b1;
        bus.reg_dst      = dec_reg_dst;
        bus.mem_to_reg   = (dec_class == CLS_LW);
        bus.inst_retired = 1'b1;
        if (dec_class == CLS_JAL) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = PC_SRC_JUMP;
        end
        state_d = S_FETCH;
      end

      S_TRAP: begin
        bus.illegal_inst = 1'b1;
      end

      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: a per-cycle vector table of
// {instruction, mem_ack, alu_zero, expected outputs}, then hand-written
// sequences for the trap hold and asynchronous reset cases.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_src;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] port_a;
    logic [1:0] port_b;
    logic [3:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       inst_retired;
    logic       illegal_inst;
  } out_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        ack;
    logic        zero;
    out_t        exp;
  } vec_t;

  localparam logic [31:0] I_ADDU  = 32'h0085_1021;
  localparam logic [31:0] I_SUBU  = 32'h0085_1023;
  localparam logic [31:0] I_LW    = 32'h8C82_0008;
  localparam logic [31:0] I_SW    = 32'hAC82_0008;
  localparam logic [31:0] I_BEQ   = 32'h1085_0004;
  localparam logic [31:0] I_BNE   = 32'h1485_0004;
  localparam logic [31:0] I_SLL   = 32'h0002_1080;
  localparam logic [31:0] I_JAL   = 32'h0C00_0010;
  localparam logic [31:0] I_J     = 32'h0800_0010;
  localparam logic [31:0] I_JR    = 32'h03E0_0008;
  localparam logic [31:0] I_LUI   = 32'h3C04_1234;
  localparam logic [31:0] I_ADDIU = 32'h2484_0001;
  localparam logic [31:0] I_ILL   = 32'hFC00_0000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[$];

  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm #(.RESET_VECTOR_WAIT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t e(input logic req, we, asrc, irw, pcw,
                             input logic [1:0] pcs, a, b,
                             input logic [3:0] op,
                             input logic rw, input logic [1:0] rd,
                             input logic m2r, ret, ill);
    out_t o;
    o = '{req, we, asrc, irw, pcw, pcs, a, b, op, rw, rd, m2r, ret, ill};
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = '{bus.mem_req, bus.mem_we, bus.mem_addr_src, bus.ir_write,
          bus.pc_write, bus.pc_src, bus.control_port_a, bus.control_port_b,
          bus.alu_op, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
          bus.inst_retired, bus.illegal_inst};
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b (fields req we asrc irw pcw pcsrc a b op rw rdst m2r ret ill)",
               name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [31:0] instr,
                     input logic ack, input logic zero, input out_t exp);
    vec_t v;
    v.name  = name;
    v.instr = instr;
    v.ack   = ack;
    v.zero  = zero;
    v.exp   = exp;
    vecs.push_back(v);
  endtask

  initial begin
    out_t z, fw, fa, trap;
    checks = 0;
    errors = 0;

    z    = e(0,0,0,0,0, 2'd0,2'd0,2'd0, 4'd0, 0,2'd0,0,0,0);
    fw   = e(1,0,0,0,0, 2'd0,2'd1,2'd3, 4'd0, 0,2'd0,0,0,0);
    fa   = e(1,0,0,1,1, 2'd0,2'd1,2'd3, 4'd0, 0,2'd0,0,0,0);
    trap = e(0,0,0,0,0, 2'd0,2'd0,2'd0, 4'd0, 0,2'd0,0,0,1);

    // First cycle after release is the single S_RESET wait cycle.
    add("rst_wait", I_ADDU, 0, 0, z);
    for (int i = 0; i < 4; i++) add("addu_fetch_wait", I_ADDU, 0, 0, fw);
    add("addu_fetch_ack", I_ADDU, 1, 0, fa);
    add("addu_decode_ack_ignored", I_ADDU, 1, 0, z);
    add("addu_exec", I_ADDU, 0, 0, e(0,0,0,0,0, 2'd0,2'd0,2'd2, 4'd0, 0,2'd0,0,0,0));
    add("addu_wb",   I_ADDU, 1, 0, e(0,0,0,0,0, 2'd0,2'd0,2'd0, 4'd0, 1,2'd1,0,1,0));

    add("lw_fetch_ack", I_LW, 1, 0, fa);
    add("lw_decode",    I_LW, 0, 0, z);
    add("lw_exec",      I_LW, 0, 0, z);
    add("lw_mem_wait",  I_LW, 0, 0, e(1,0,1,0,0, 2'd0,2'd0,2'd0, 4'd0, 0,2'd0,0,0,0));
    add("lw_mem_ack",   I_LW, 1, 0, e(1,0,1,0,0, 2'd0,2'd0,2'd0, 4'd0, 0,2'd0,0,0,0));
    add("lw_wb",        I_LW, 0, 0, e(0,0,0,0,0, 2'd0,2'd0,2'd0, 4'd0, 1,2'd0,1,1,0));

    add("sw_fetch_ack", I_SW, 1, 0, fa);
    add("sw_decode",    I_SW, 0, 0, z);
    add("sw_exec",      I_SW, 0, 0, z);
    add("sw_mem_ack",   I_SW, 1, 0, e(1,1,1,0,0, 2'd0,2'd0,2'd0, 4'd0, 0,2'd0,0,1,0));

    add("beq_t_fetch_ack", I_BEQ, 1, 1, fa);
    add("beq_t_decode",    I_BEQ, 0, 1, z);
    add("beq_t_exec",      I_BEQ, 0, 1, e(0,0,0,0,1, 2'd1,2'd0,2'd2, 4'd1, 0,2'd0,0,1,0));
    add("beq_nt_fetch_ack", I_BEQ, 1, 0, fa);
    add("beq_nt_decode",    I_BEQ, 0, 0, z);
    add("beq_nt_exec",      I_BEQ, 0, 0, e(0,0,0,0,0, 2'd1,2'd0,2'd2, 4'd1, 0,2'd0,0,1,0));
    add("bne_t_fetch_ack", I_BNE, 1, 0, fa);
    add("bne_t_decode",    I_BNE, 0, 0, z);
    add("bne_t_exec",      I_BNE, 0, 0, e(0,0,0,0,1, 2'd1,2'd0,2'd2, 4'd1, 0,2'd0,0,1,0));

    add("sll_fetch_ack", I_SLL, 1, 0, fa);
    add("sll_decode",    I_SLL, 0, 0, z);
    add("sll_exec",      I_SLL, 0, 0, e(0,0,0,0,0, 2'd0,2'd2,2'd1, 4'd5, 0,2'd0,0,0,0));
    add("sll_wb",        I_SLL, 0, 0, e(0,0,0,0,0, 2'd0,2'd0,2'd0, 4'd0, 1,2'd1,0,1,0));

    add("jal_fetch_ack", I_JAL, 1, 0, fa);
    add("jal_decode",    I_JAL, 0, 0, z);
    add("jal_exec",      I_JAL, 0, 0, e(0,0,0,0,0, 2'd0,2'd1,2'd0, 4'd8, 0,2'd0,0,0,0));
    add("jal_wb",        I_JAL, 0, 0, e(0,0,0,0,1, 2'd2,2'd0,2'd0, 4'd0, 1,2'd2,0,1,0));

    add("j_fetch_ack", I_J, 1, 0, fa);
    add("j_decode",    I_J, 0, 0, z);
    add("j_exec",      I_J, 0, 0, e(0,0,0,0,1, 2'd2,2'd0,2'd0, 4'd0, 0,2'd0,0,1,0));
    add("jr_fetch_ack", I_JR, 1, 0, fa);
    add("jr_decode",    I_JR, 0, 0, z);
    add("jr_exec",      I_JR, 0, 0, e(0,0,0,0,1, 2'd3,2'd0,2'd0, 4'd0, 0,2'd0,0,1,0));

    add("lui_fetch_ack", I_LUI, 1, 0, fa);
    add("lui_decode",    I_LUI, 0, 0, z);
    add("lui_exec",      I_LUI, 0, 0, e(0,0,0,0,0, 2'd0,2'd0,2'd0, 4'd7, 0,2'd0,0,0,0));
    add("lui_wb",        I_LUI, 0, 0, e(0,0,0,0,0, 2'd0,2'd0,2'd0, 4'd0, 1,2'd0,0,1,0));
    add("addiu_fetch_ack", I_ADDIU, 1, 0, fa);
    add("addiu_decode",    I_ADDIU, 0, 0, z);
    add("addiu_exec",      I_ADDIU, 0, 0, z);
    add("addiu_wb",        I_ADDIU, 0, 0, e(0,0,0,0,0, 2'd0,2'd0,2'd0, 4'd0, 1,2'd0,0,1,0));
    add("subu_fetch_ack", I_SUBU, 1, 0, fa);
    add("subu_decode",    I_SUBU, 0, 0, z);
    add("subu_exec",      I_SUBU, 0, 0, e(0,0,0,0,0, 2'd0,2'd0,2'd2, 4'd1, 0,2'd0,0,0,0));
    add("subu_wb",        I_SUBU, 0, 0, e(0,0,0,0,0, 2'd0,2'd0,2'd0, 4'd0, 1,2'd1,0,1,0));

    add("ill_fetch_ack", I_ILL, 1, 0, fa);
    add("ill_decode",    I_ILL, 0, 0, z);

    // Reset held for three cycles with strobes low.
    rst             = 1'b1;
    bus.instruction = '0;
    bus.mem_ack     = 1'b0;
    bus.alu_zero    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("reset_hold", sample(), z);
    end

    // Table: inputs driven at the falling edge, outputs checked 1 unit later.
    foreach (vecs[i]) begin
      @(negedge clk);
      rst             = 1'b0;
      bus.instruction = vecs[i].instr;
      bus.mem_ack     = vecs[i].ack;
      bus.alu_zero    = vecs[i].zero;
      #1 check($sformatf("%s[%0d]", vecs[i].name, i), sample(), vecs[i].exp);
    end

    // Trap is sticky and never touches memory, whatever mem_ack does.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.mem_ack = i[0];
      #1 check($sformatf("trap_hold[%0d]", i), sample(), trap);
    end

    // Asynchronous reset out of the trap clears illegal_inst immediately.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("trap_async_rst", sample(), z);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Store held in S_MEM, then reset mid-cycle drops mem_req/mem_we at once.
    rst             = 1'b0;
    bus.instruction = I_SW;
    #1 check("sw2_rst_wait", sample(), z);
    @(negedge clk);
    bus.mem_ack = 1'b1;
    #1 check("sw2_fetch_ack", sample(), fa);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1 check("sw2_decode", sample(), z);
    @(negedge clk);
    #1 check("sw2_exec", sample(), z);
    @(negedge clk);
    #1 check("sw2_mem_wait", sample(), e(1,1,1,0,0, 2'd0,2'd0,2'd0, 4'd0, 0,2'd0,0,0,0));
    #2 rst = 1'b1;
    #1 check("sw2_async_rst", sample(), z);
    @(negedge clk);
    #1 check("sw2_rst_hold", sample(), z);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
